// File: rtl/demod_qpsk.sv
// rtl/demod_qpsk.sv - QPSK integrate-and-dump demodulator with flush delay and symbol alignment
module demod_qpsk #(
  parameter int SPS       = 8,
  parameter int SPAN      = 16,
  parameter int BIT_SYM   = 2,
  parameter int BIT_DAC   = 14,
  parameter int DELAY_SYM = SPAN / 2
) (
  input  logic                                  clock_sample,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  align,
  input  logic signed [BIT_DAC-1:0]             if_in,
  output logic [BIT_SYM-1:0]                    sym_out,
  output logic                                  sym_valid,
  output logic signed [BIT_DAC+$clog2(SPS)-2:0] soft_i,
  output logic signed [BIT_DAC+$clog2(SPS)-2:0] soft_q,
  output logic                                  locked
);

  localparam int CW = $clog2(SPS);
  localparam int SW = BIT_DAC + CW - 1;
  localparam int FW = $clog2(DELAY_SYM + 2);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FW-1:0]         flush_q, flush_d;
  logic signed [SW-1:0]  acc_i_q, acc_i_d;
  logic signed [SW-1:0]  acc_q_q, acc_q_d;
  logic signed [SW-1:0]  soft_i_q, soft_i_d;
  logic signed [SW-1:0]  soft_q_q, soft_q_d;
  logic [BIT_SYM-1:0]    sym_q, sym_d;
  logic                  valid_q, valid_d;

  logic signed [SW-1:0]  if_ext, mix;
  logic signed [SW-1:0]  base_i, base_q;
  logic signed [SW-1:0]  final_i, final_q;
  logic                  is_i, last;

  // Carrier at fs/4: sign pattern -,-,+,+ repeats every four samples.
  assign if_ext  = SW'(if_in);
  assign mix     = cnt_q[1] ? if_ext : -if_ext;
  assign is_i    = ~cnt_q[0];
  assign last    = (cnt_q == CW'(SPS - 1));
  assign base_i  = (cnt_q == '0) ? '0 : acc_i_q;
  assign base_q  = (cnt_q == '0) ? '0 : acc_q_q;
  // The last sample of a symbol is always a Q sample, so I is already complete.
  assign final_i = acc_i_q;
  assign final_q = acc_q_q + mix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    soft_i_d = soft_i_q;
    soft_q_d = soft_q_q;
    sym_d    = sym_q;
    valid_d  = 1'b0;

    if (state_q == S_IDLE) begin
      cnt_d   = '0;
      acc_i_d = '0;
      acc_q_d = '0;
      if (enable) begin
        if (DELAY_SYM == 0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_FLUSH;
          flush_d = FW'(DELAY_SYM);
        end
      end
    end else if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      flush_d = '0;
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (align) begin
      cnt_d   = '0;
      acc_i_d = '0;
      acc_q_d = '0;
    end else begin
      cnt_d   = cnt_q + CW'(1);
      acc_i_d = is_i ? base_i + mix : base_i;
      acc_q_d = is_i ? base_q : base_q + mix;
      if (last) begin
        if (state_q == S_RUN) begin
          soft_i_d = final_i;
          soft_q_d = final_q;
          sym_d    = BIT_SYM'({final_q[SW-1], final_i[SW-1]});
          valid_d  = 1'b1;
        end else begin
          flush_d = flush_q - FW'(1);
          if (flush_q == FW'(1)) begin
            state_d = S_RUN;
          end
        end
      end
    end
  end

  always_ff @(posedge clock_sample) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      flush_q  <= '0;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      soft_i_q <= '0;
      soft_q_q <= '0;
      sym_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      soft_i_q <= soft_i_d;
      soft_q_q <= soft_q_d;
      sym_q    <= sym_d;
      valid_q  <= valid_d;
    end
  end

  assign sym_out   = sym_q;
  assign sym_valid = valid_q;
  assign soft_i    = soft_i_q;
  assign soft_q    = soft_q_q;
  assign locked    = (state_q == S_RUN);

endmodule
